id_stage: RTL

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_pkg.sv | 89 ++++++++
 rtl/id_stage_regfile.sv | 51 +++++
 rtl/id_stage.sv | 139 +++++++++++++
 3 files changed

// File: rtl/id_pkg.sv
// Shared decode definitions for the instruction-decode stage: opcodes,
// special instruction encodings, ID/EXE bus layout and decode helpers.
package id_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned REG_AW      = 5;
  localparam int unsigned IF_ID_BUS_W = 64;

  // ID/EXE bus layout: valid, pc, inst, rs1_data, rs2_data, imm, rd
  localparam int unsigned ID_EXE_BUS_W     = 166;
  localparam int unsigned ID_EXE_VALID_BIT = 165;
  localparam int unsigned ID_EXE_PC_LSB    = 133;
  localparam int unsigned ID_EXE_INST_LSB  = 101;
  localparam int unsigned ID_EXE_RS1_LSB   = 69;
  localparam int unsigned ID_EXE_RS2_LSB   = 37;
  localparam int unsigned ID_EXE_IMM_LSB   = 5;
  localparam int unsigned ID_EXE_RD_LSB    = 0;

  localparam logic [XLEN-1:0] NOP_INST   = 32'h0000_0033;
  localparam logic [XLEN-1:0] ECALL_INST = 32'h0000_0073;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_NONE
  } imm_fmt_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } if_id_reg_t;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   inst;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rd;
  } id_exe_bus_t;

  // Immediate format selected purely by opcode
  function automatic imm_fmt_e imm_fmt(input logic [6:0] opcode);
    imm_fmt_e fmt;
    fmt = FMT_NONE;
    case (opcode)
      OPC_OP:                                    fmt = FMT_R;
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: fmt = FMT_I;
      OPC_STORE:                                 fmt = FMT_S;
      OPC_BRANCH:                                fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:                        fmt = FMT_U;
      OPC_JAL:                                   fmt = FMT_J;
      default:                                   fmt = FMT_NONE;
    endcase
    return fmt;
  endfunction

  // Opcodes that produce a register result (SYSTEM only for CSR forms)
  function automatic logic writes_rd(input logic [6:0] opcode, input logic [2:0] funct3);
    logic wr;
    wr = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
      OPC_LOAD, OPC_OP_IMM, OPC_OP:       wr = 1'b1;
      OPC_SYSTEM:                          wr = (funct3 != 3'b000);
      default:                             wr = 1'b0;
    endcase
    return wr;
  endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port, x0 hard-wired to zero. Same-cycle write-to-read bypass when
// ID_BYPASS_EN is defined.
module regfile
  import id_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [XLEN-1:0]   rdata1,
  output logic [XLEN-1:0]   rdata2,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata
);

  localparam int unsigned NUM_REGS = 32;

  logic [XLEN-1:0] regs [NUM_REGS];

  // Write port; x0 is never written so it stays zero after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '{default: '0};
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Read port 1, optionally forwarding the in-flight write
  always_comb begin
    rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
`ifdef ID_BYPASS_EN
    if (we && (waddr != '0) && (waddr == raddr1)) begin
      rdata1 = wdata;
    end
`endif
  end

  // Read port 2, optionally forwarding the in-flight write
  always_comb begin
    rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];
`ifdef ID_BYPASS_EN
    if (we && (waddr != '0) && (waddr == raddr2)) begin
      rdata2 = wdata;
    end
`endif
  end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: IF/ID pipeline register, register-file read,
// immediate/rd decode, load-use and write-back hazard stall, ECALL detect.
// Optional macro ID_BYPASS_EN: forward same-cycle write-back data to the
// register reads instead of stalling on a write-back/read collision.
module id_stage
  import id_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [IF_ID_BUS_W-1:0]  if_id_bus_in,
  input  logic                    flush_in,
  input  logic                    exe_load_flag,
  input  logic [REG_AW-1:0]       exe_rd,
  input  logic                    wb_we,
  input  logic [REG_AW-1:0]       wb_addr,
  input  logic [XLEN-1:0]         wb_data,
  output logic                    stall_out,
  output logic                    ecall_out,
  output logic [ID_EXE_BUS_W-1:0] id_exe_bus_out
);

  if_id_reg_t        if_id_q;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [REG_AW-1:0] rd_field;
  imm_fmt_e          fmt;
  logic              rs1_used;
  logic              rs2_used;
  logic              load_use;
  logic              src_hazard;
  logic              issue;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic [XLEN-1:0]   imm;
  id_exe_bus_t       bus;

  // True when addr is nonzero and names a source the instruction reads
  function automatic logic src_match(input logic [REG_AW-1:0] addr,
                                     input logic [REG_AW-1:0] s1, input logic u1,
                                     input logic [REG_AW-1:0] s2, input logic u2);
    return (addr != '0) && ((u1 && (addr == s1)) || (u2 && (addr == s2)));
  endfunction

  // IF/ID register: flush squashes to an invalid NOP, stall holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_q <= '{valid: 1'b0, inst: NOP_INST, pc: '0};
    end else if (flush_in) begin
      if_id_q.valid <= 1'b0;
      if_id_q.inst  <= NOP_INST;
    end else if (!stall_out) begin
      if_id_q <= '{valid: 1'b1,
                   inst:  if_id_bus_in[63:32],
                   pc:    if_id_bus_in[31:0]};
    end
  end

  assign opcode   = if_id_q.inst[6:0];
  assign funct3   = if_id_q.inst[14:12];
  assign rs1      = if_id_q.inst[19:15];
  assign rs2      = if_id_q.inst[24:20];
  assign rd_field = if_id_q.inst[11:7];
  assign fmt      = imm_fmt(opcode);

  // Source operand usage by instruction class
  always_comb begin
    rs1_used = !(opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
    rs2_used = (fmt inside {FMT_R, FMT_S, FMT_B});
  end

  // Load-use hazard against the load currently in EXE
  always_comb begin
    load_use = exe_load_flag && src_match(exe_rd, rs1, rs1_used, rs2, rs2_used);
  end

`ifdef ID_BYPASS_EN
  assign src_hazard = load_use;
`else
  logic wb_hazard;

  // Without forwarding, wait one cycle for the write-back to land
  always_comb begin
    wb_hazard = wb_we && src_match(wb_addr, rs1, rs1_used, rs2, rs2_used);
  end

  assign src_hazard = load_use || wb_hazard;
`endif

  assign stall_out = if_id_q.valid && !flush_in && src_hazard;
  assign issue     = if_id_q.valid && !flush_in && !stall_out;
  assign ecall_out = issue && (if_id_q.inst == ECALL_INST);

  regfile u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data),
    .we     (wb_we),
    .waddr  (wb_addr),
    .wdata  (wb_data)
  );

  // Immediate generation by format, sign-extended where applicable
  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I: imm = {{20{if_id_q.inst[31]}}, if_id_q.inst[31:20]};
      FMT_S: imm = {{20{if_id_q.inst[31]}}, if_id_q.inst[31:25], if_id_q.inst[11:7]};
      FMT_B: imm = {{20{if_id_q.inst[31]}}, if_id_q.inst[7], if_id_q.inst[30:25],
                    if_id_q.inst[11:8], 1'b0};
      FMT_U: imm = {if_id_q.inst[31:12], 12'h000};
      FMT_J: imm = {{12{if_id_q.inst[31]}}, if_id_q.inst[19:12], if_id_q.inst[20],
                    if_id_q.inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  // ID/EXE payload: decoded instruction when issuing, otherwise a bubble
  always_comb begin
    bus = '{valid: 1'b0, pc: '0, inst: NOP_INST, rs1_data: '0,
            rs2_data: '0, imm: '0, rd: '0};
    if (issue) begin
      bus.valid    = 1'b1;
      bus.pc       = if_id_q.pc;
      bus.inst     = if_id_q.inst;
      bus.rs1_data = rs1_data;
      bus.rs2_data = rs2_data;
      bus.imm      = imm;
      bus.rd       = writes_rd(opcode, funct3) ? rd_field : '0;
    end
  end

  assign id_exe_bus_out = bus;

endmodule
